// File: rtl/usi_spi_target.sv
// SPI mode-0 target: oversamples sclk/nss/mosi in the clk domain, receives MSB-first
// bytes on sd0 and returns bytes from a one-deep TX holding register on sd1.
module usi_spi_target #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk_in,
  input  logic       nss_in,
  input  logic       sd0_in,
  output logic       sd1_out,
  output logic       sd1_oe_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_ovf,
  output logic       tx_udf,
  output logic       frame_err
);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] nss_sync;
  logic [SYNC_STAGES-1:0] sd0_sync_q;
  logic                   sclk_d;
  logic                   nss_d;
  logic                   sclk_s;
  logic                   nss_s;
  logic                   sd0_sync;
  logic                   sclk_rise;
  logic                   sclk_fall;
  logic                   nss_fall;
  logic                   nss_rise;

  state_t                 state;
  state_t                 state_next;
  logic                   frame_start;
  logic                   frame_end;
  logic                   sample;
  logic                   shift;

  logic [2:0]             bit_cnt;
  logic [7:0]             rx_shift;
  logic [7:0]             tx_shift;
  logic [7:0]             hold_data;
  logic                   hold_full;
  logic                   tx_load;
  logic                   byte_done;
  logic [7:0]             rx_byte;

  // nss resets high so leaving reset never looks like a chip-select fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync  <= '0;
      nss_sync   <= '1;
      sd0_sync_q <= '0;
      sclk_d     <= 1'b0;
      nss_d      <= 1'b1;
    end else begin
      sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
      nss_sync   <= {nss_sync[SYNC_STAGES-2:0], nss_in};
      sd0_sync_q <= {sd0_sync_q[SYNC_STAGES-2:0], sd0_in};
      sclk_d     <= sclk_sync[SYNC_STAGES-1];
      nss_d      <= nss_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign nss_s     = nss_sync[SYNC_STAGES-1];
  assign sd0_sync  = sd0_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign nss_fall  = ~nss_s & nss_d;
  assign nss_rise  = nss_s & ~nss_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every signal driven here gets a default first, so no path infers a latch.
  always_comb begin
    state_next  = state;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    sample      = 1'b0;
    shift       = 1'b0;
    case (state)
      IDLE: begin
        if (nss_fall) begin
          state_next  = ACTIVE;
          frame_start = 1'b1;
        end
      end
      ACTIVE: begin
        // A chip-select release masks any sclk edge seen in the same cycle.
        if (nss_rise) begin
          state_next = IDLE;
          frame_end  = 1'b1;
        end else begin
          sample = sclk_rise;
          shift  = sclk_fall;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign tx_load   = frame_start | (shift & (bit_cnt == 3'd0));
  assign byte_done = sample & (bit_cnt == 3'd7);
  assign rx_byte   = {rx_shift[6:0], sd0_sync};

  // NOTE: the data registers are reset as well, so a reset can never leave a stale byte behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= 3'd0;
      rx_shift  <= 8'h00;
      tx_shift  <= 8'hFF;
      hold_data <= 8'h00;
      hold_full <= 1'b0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      rx_ovf    <= 1'b0;
      tx_udf    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_ovf    <= 1'b0;
      tx_udf    <= 1'b0;
      frame_err <= frame_end & (bit_cnt != 3'd0);

      if (frame_start || frame_end) bit_cnt <= 3'd0;
      else if (sample)              bit_cnt <= bit_cnt + 3'd1;

      if (sample) rx_shift <= rx_byte;

      if (byte_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= rx_byte;
          rx_valid <= 1'b1;
        end else begin
          rx_ovf <= 1'b1;
        end
      end else if (rx_ready) begin
        rx_valid <= 1'b0;
      end

      if (tx_load) begin
        if (hold_full) begin
          tx_shift <= hold_data;
        end else begin
          tx_shift <= 8'hFF;
          tx_udf   <= 1'b1;
        end
      end else if (shift) begin
        tx_shift <= {tx_shift[6:0], 1'b1};
      end

      // A write can only land while empty, so a same-cycle load leaves the new byte held.
      if (tx_valid && !hold_full) begin
        hold_data <= tx_data;
        hold_full <= 1'b1;
      end else if (tx_load) begin
        hold_full <= 1'b0;
      end
    end
  end

  assign sd1_out  = tx_shift[7];
  assign sd1_oe_n = (state != ACTIVE);
  assign tx_ready = ~hold_full;

endmodule
